// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with start/done/abort handshake and its own controller.
// Define BOOTH_RADIX4_EN to select modified-Booth (radix-4) recoding; radix-2 otherwise.
module booth_mult_seq #(
  parameter int N = 16,
  parameter int W = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

`ifdef BOOTH_RADIX4_EN
  // Two guard bits so that adding -2M to a partial sum cannot overflow A.
  localparam int AW   = N + 2;
  localparam int ITER = N / 2;
`else
  // One guard bit so that -M for M = -2^(N-1) still fits.
  localparam int AW   = N + 1;
  localparam int ITER = N;
`endif

  generate
    if (N < 4) begin : g_bad_width
      $error("booth_mult_seq: N must be at least 4");
    end
`ifdef BOOTH_RADIX4_EN
    if ((N % 2) != 0) begin : g_bad_parity
      $error("booth_mult_seq: N must be even for radix-4 recoding");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [AW-1:0]    a_r;
  logic [N-1:0]     q_r;
  logic             qm1_r;
  logic [N-1:0]     m_r;
  logic [W-1:0]     count_r;
  logic [2*N-1:0]   product_r;
  logic             busy_r;
  logic             done_r;

  logic             load_s;
  logic             step_s;
  logic             finish_s;
  logic [AW-1:0]    m_ext_s;
  logic [AW-1:0]    addend_s;
  logic [AW-1:0]    sum_s;
  logic [AW-1:0]    a_shift_s;
  logic [N-1:0]     q_shift_s;
  logic             qm1_shift_s;

  assign m_ext_s = {{(AW - N){m_r[N-1]}}, m_r};

  // Booth recoding of the low multiplier bits into the partial-product addend.
  always_comb begin
    addend_s = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_r[1:0], qm1_r})
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = {m_ext_s[AW-2:0], 1'b0};
      3'b100:         addend_s = -{m_ext_s[AW-2:0], 1'b0};
      3'b101, 3'b110: addend_s = -m_ext_s;
      default:        addend_s = '0;
    endcase
`else
    case ({q_r[0], qm1_r})
      2'b01:   addend_s = m_ext_s;
      2'b10:   addend_s = -m_ext_s;
      default: addend_s = '0;
    endcase
`endif
  end

  assign sum_s = a_r + addend_s;

  // Arithmetic right shift of the combined {A, Q, Q[-1]} register after the add.
  always_comb begin
`ifdef BOOTH_RADIX4_EN
    a_shift_s   = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    q_shift_s   = {sum_s[1:0], q_r[N-1:2]};
    qm1_shift_s = q_r[1];
`else
    a_shift_s   = {sum_s[AW-1], sum_s[AW-1:1]};
    q_shift_s   = {sum_s[0], q_r[N-1:1]};
    qm1_shift_s = q_r[0];
`endif
  end

  // Controller next-state logic; abort takes priority over the final iteration.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (count_r == W'(1)) begin
          step_s       = 1'b1;
          finish_s     = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          step_s       = 1'b1;
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and per-iteration datapath update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      q_r     <= '0;
      qm1_r   <= 1'b0;
      m_r     <= '0;
      count_r <= '0;
    end else if (load_s) begin
      a_r     <= '0;
      q_r     <= multiplier;
      qm1_r   <= 1'b0;
      m_r     <= multiplicand;
      count_r <= W'(ITER);
    end else if (step_s) begin
      a_r     <= a_shift_s;
      q_r     <= q_shift_s;
      qm1_r   <= qm1_shift_s;
      count_r <= count_r - W'(1);
    end else begin
      a_r     <= a_r;
      q_r     <= q_r;
      qm1_r   <= qm1_r;
      m_r     <= m_r;
      count_r <= count_r;
    end
  end

  // Product is latched from the final shifted value on entry to DONE and held until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= '0;
    end else if (finish_s) begin
      product_r <= {a_shift_s[N-1:0], q_shift_s};
    end else begin
      product_r <= product_r;
    end
  end

  // Handshake outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed table at N=8, handshake corner cases,
// and random products at N=8 and N=16 compared against plain signed multiplication.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int ITER8  = 4;
  localparam int ITER16 = 8;
`else
  localparam int ITER8  = 8;
  localparam int ITER16 = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        start8, abort8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;
  logic        start16, abort16, busy16, done16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;

  int pass_cnt  = 0;
  int total_cnt = 0;

  booth_mult_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .multiplicand(mc8), .multiplier(mp8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_seq #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
    .multiplicand(mc16), .multiplier(mp16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] m, input logic [7:0] q);
    longint r;
    r = longint'($signed(m)) * longint'($signed(q));
    return r[15:0];
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] m, input logic [15:0] q);
    longint r;
    r = longint'($signed(m)) * longint'($signed(q));
    return r[31:0];
  endfunction

  // One full N=8 operation; lat counts edges from the start edge until done is seen.
  task automatic run8(input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int lat, output int bcnt);
    @(negedge clk);
    mc8 = m; mp8 = q; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    mc8 = ~m; mp8 = ~q;
    lat = 1;
    bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
    p = prod8;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] m, input logic [15:0] q,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    mc16 = m; mp16 = q; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    p = prod16;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h80;
      1:       v = 8'h7F;
      2:       v = 8'hFF;
      3:       v = 8'h00;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h8000;
      1:       v = 16'h7FFF;
      2:       v = 16'hFFFF;
      3:       v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [15:0] prev;
    int          lat, bcnt, seen;

    vecs[0] = '{8'd7,   8'hFD, 16'hFFEB};
    vecs[1] = '{8'h80,  8'h80, 16'h4000};
    vecs[2] = '{8'h7F,  8'h7F, 16'h3F01};
    vecs[3] = '{8'h80,  8'h7F, 16'hC080};
    vecs[4] = '{8'h00,  8'hFF, 16'h0000};
    vecs[5] = '{8'd5,   8'd6,  16'h001E};

    rst_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; mc8 = 8'h00; mp8 = 8'h00;
    start16 = 1'b0; abort16 = 1'b0; mc16 = 16'h0000; mp16 = 16'h0000;
    #12;
    check("reset_busy", {63'd0, busy8}, 64'd0);
    check("reset_done", {63'd0, done8}, 64'd0);
    check("reset_product", {48'd0, prod8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].m, vecs[i].q, p8, lat, bcnt);
      check($sformatf("tbl%0d_product", i), {48'd0, p8}, {48'd0, vecs[i].p});
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(ITER8 + 1));
      check($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'(ITER8 + 1));
      check($sformatf("tbl%0d_idle_after", i), {62'd0, busy8, done8}, 64'd0);
      check($sformatf("tbl%0d_held", i), {48'd0, prod8}, {48'd0, vecs[i].p});
    end

    // Start re-asserted with new operands during RUN is ignored.
    @(negedge clk);
    mc8 = 8'd7; mp8 = 8'hFD; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    mc8 = 8'd100; mp8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 2;
    while (!done8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("restart_ignored_product", {48'd0, prod8}, 64'h0000_0000_0000_FFEB);
    check("restart_ignored_latency", 64'(lat), 64'(ITER8 + 1));
    @(posedge clk); #1;

    // Abort on the 4th RUN cycle: no done, IDLE next cycle, product unchanged.
    prev = 16'hFFEB;
    @(negedge clk);
    mc8 = 8'd3; mp8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    check("abort_busy", {63'd0, busy8}, 64'd0);
    check("abort_done", {63'd0, done8}, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_product_kept", {48'd0, prod8}, {48'd0, prev});

    // Asynchronous reset between edges during RUN.
    @(negedge clk);
    mc8 = 8'd11; mp8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy8}, 64'd0);
    check("async_rst_done", {63'd0, done8}, 64'd0);
    check("async_rst_product", {48'd0, prod8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'd11, 8'd13, p8, lat, bcnt);
    check("post_rst_product", {48'd0, p8}, 64'd143);
    check("post_rst_latency", 64'(lat), 64'(ITER8 + 1));

    // Random N=8 against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] m, q;
      m = pick8();
      q = pick8();
      run8(m, q, p8, lat, bcnt);
      check($sformatf("rnd8 %0h*%0h", m, q), {48'd0, p8}, {48'd0, model8(m, q)});
    end

    // Random N=16 against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] m, q;
      m = pick16();
      q = pick16();
      run16(m, q, p16, lat);
      check($sformatf("rnd16 %0h*%0h", m, q), {32'd0, p16}, {32'd0, model16(m, q)});
      if (i == 0) check("rnd16_latency", 64'(lat), 64'(ITER16 + 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
